wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback (Data_D/Addr_D from
//  the memory-access stage) and a multi-cycle unit (mul/div, CSR reads). The pipeline has priority; multi-cycle
//  results are buffered in a small FIFO and drained on idle cycles, with a starvation stall to force progress.
//  Sits between the memory-access stage and the RegFile write port.
// PARAMETERS
//  DEPTH        2   multi-cycle result FIFO entries; power of 2, >=2
//  STARVE_LIMIT 4   consecutive cycles FIFO head may lose arbitration before stall_pipe asserts; 1..15
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  pipe_we     in   1   pipeline writeback valid (no backpressure except via stall_pipe)
//  pipe_rd     in   5   pipeline destination register
//  pipe_data   in   32  pipeline writeback data
//  mc_valid    in   1   multi-cycle result valid
//  mc_ready    out  1   FIFO can accept; transfer when mc_valid & mc_ready
//  mc_rd       in   5   multi-cycle destination register
//  mc_data     in   32  multi-cycle result
//  rf_we       out  1   registered RegFile write enable
//  rf_rd       out  5   registered RegFile write address
//  rf_wd       out  32  registered RegFile write data
//  stall_pipe  out  1   registered; pipeline must hold pipe_we=0 while high
//  fifo_count  out  clog2(DEPTH)+1  valid FIFO entries
//  proto_err   out  1   sticky: pipe_we seen while stall_pipe=1
// BEHAVIOUR
//  - Reset: rf_we=0, rf_rd=0, rf_wd=0, stall_pipe=0, proto_err=0, FIFO empty, starve_cnt=0, mc_ready=1.
//    Reset mid-operation discards all buffered results; no partial write is emitted.
//  - mc_ready = (fifo_count != DEPTH), from registered state only; push+pop in a full cycle still sees ready=0.
//  - Per-cycle grant (combinational), result registered onto rf_* at next edge (latency 1):
//    1) stall_pipe=1 -> FIFO head granted; pipe_we ignored, proto_err set if pipe_we=1.
//    2) else pipe_we & pipe_rd!=0 -> pipeline granted.
//    3) else FIFO non-empty -> head granted.  4) else rf_we<=0.
//  - rd==0: pipeline write to x0 yields rf_we=0 and frees the port for the FIFO head that cycle.
//    mc transfer with mc_rd==0 is accepted and dropped (not enqueued).
//  - Kill rule: a granted pipeline write to rd=R marks every valid FIFO entry with rd=R killed, plus an
//    mc transfer to R in the same cycle (pipeline result is program-order younger). Killed head pops
//    without a write, in parallel with the pipeline write; a killed head never resets starve_cnt logic.
//  - Starvation: starve_cnt increments each cycle a live (unkilled) head exists and pipeline wins;
//    clears when the head writes or FIFO empties. starve_cnt==STARVE_LIMIT-1 with a loss -> stall_pipe<=1
//    for exactly one cycle, during which the head writes; counter then clears.
//  - FIFO: circular, pointers wrap modulo DEPTH; simultaneous push/pop keeps count; pop from empty impossible.
//  - Ordering: FIFO entries write in arrival order; mc results never reorder among themselves.
// CONFIGURATION
//  WB_ARB_BYPASS_EN defined: mc transfer with FIFO empty, stall_pipe=0 and no granted pipeline write in the
//   same cycle bypasses the FIFO -> rf_* next edge (mc_valid to rf_we latency 1).
//  Not defined: every mc result is enqueued first; minimum mc_valid to rf_we latency 2. Behaviour otherwise identical.
// TESTING
//  1 pipe_we=1 rd=5 data=0xDEADBEEF, FIFO empty -> next cycle rf_we=1 rf_rd=5 rf_wd=0xDEADBEEF.
//  2 mc push rd=7 data=0x11 while pipe idle -> rf write rd=7 after 2 cycles (1 with WB_ARB_BYPASS_EN).
//  3 Pipe writes every cycle, mc push rd=9, STARVE_LIMIT=4 -> stall_pipe high in 5th cycle, rf write rd=9
//    next edge, stall_pipe low after one cycle, fifo_count back to 0.
//  4 DEPTH=2: push rd=3, rd=4 with pipe busy -> mc_ready=0, fifo_count=2; third mc_valid held until a pop.
//  5 FIFO holds rd=6 data=0xA; pipe writes rd=6 data=0xB -> only 0xB written, entry popped with rf_we=0.
//  6 Assert rst with 2 entries queued and rf_we=1 -> all outputs 0 immediately, fifo_count=0, no later writes.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback port arbitration bundle.
// Pipeline writeback, multi-cycle result handshake, RegFile write port and status.
// master = producer/consumer side (pipeline, mc unit, regfile); slave = arbiter.
interface wb_port_arbiter_if #(
  parameter int DEPTH = 2
);
  logic                    pipe_we;
  logic [4:0]              pipe_rd;
  logic [31:0]             pipe_data;
  logic                    mc_valid;
  logic                    mc_ready;
  logic [4:0]              mc_rd;
  logic [31:0]             mc_data;
  logic                    rf_we;
  logic [4:0]              rf_rd;
  logic [31:0]             rf_wd;
  logic                    stall_pipe;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    proto_err;

  modport master (
    output pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    input  mc_ready, rf_we, rf_rd, rf_wd, stall_pipe, fifo_count, proto_err
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    output mc_ready, rf_we, rf_rd, rf_wd, stall_pipe, fifo_count, proto_err
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RegFile write port between pipeline writeback
// (priority) and a multi-cycle unit whose results queue in a small FIFO.
// A head that keeps losing forces a one-cycle stall_pipe so it can drain.
// Optional feature macro: WB_ARB_BYPASS_EN (mc result straight to rf_* when
// the FIFO is empty and the port is free).
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [AW-1:0]    r_rptr, r_wptr;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_starve;
  logic             r_stall, r_err;
  logic             r_we;
  logic [4:0]       r_rf_rd;
  logic [31:0]      r_rf_wd;

  logic w_empty, w_full, w_xfer, w_pipe_gnt, w_head_kill, w_live;
  logic w_pop, w_head_wr, w_lose, w_mc_kill, w_mc_keep, w_byp, w_push;

  // Grant decision, kill detection and FIFO push/pop for this cycle
  always_comb begin
    w_empty     = (r_cnt == '0);
    w_full      = (r_cnt == CW'(DEPTH));
    w_xfer      = bus.mc_valid & ~w_full;
    // x0 writes never take the port, so the head may use it instead
    w_pipe_gnt  = ~r_stall & bus.pipe_we & (bus.pipe_rd != 5'd0);
    // head is dead if marked earlier or overwritten by this cycle's pipe write
    w_head_kill = r_kill[r_rptr] | (w_pipe_gnt & (r_rd[r_rptr] == bus.pipe_rd));
    w_live      = ~w_empty & ~w_head_kill;
    // when the pipe owns the port only a dead head can leave (silently)
    w_pop       = ~w_empty & (w_pipe_gnt ? w_head_kill : 1'b1);
    w_head_wr   = w_pop & ~w_head_kill;
    w_lose      = w_live & w_pipe_gnt;
    w_mc_kill   = w_pipe_gnt & (bus.mc_rd == bus.pipe_rd);
    w_mc_keep   = w_xfer & (bus.mc_rd != 5'd0) & ~w_mc_kill;
`ifdef WB_ARB_BYPASS_EN
    w_byp       = w_mc_keep & w_empty & ~r_stall & ~w_pipe_gnt;
`else
    w_byp       = 1'b0;
`endif
    w_push      = w_mc_keep & ~w_byp;
  end

  // FIFO storage, pointers, kill marks, starvation counter, protocol flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_kill   <= '0;
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // stale slots may get marked too; a push clears the mark on reuse
      for (int i = 0; i < DEPTH; i++)
        if (w_pipe_gnt && (r_rd[i] == bus.pipe_rd)) r_kill[i] <= 1'b1;
      if (w_push) begin
        r_rd[r_wptr]   <= bus.mc_rd;
        r_data[r_wptr] <= bus.mc_data;
        r_kill[r_wptr] <= 1'b0;
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      // a silently dropped head does not count as progress
      if (w_head_wr || w_empty) r_starve <= '0;
      else if (w_lose)          r_starve <= r_starve + 4'd1;
      r_stall <= w_lose && (r_starve == 4'(STARVE_LIMIT - 1));
      r_err   <= r_err | (r_stall & bus.pipe_we);
    end
  end

  // Registered RegFile write port (pipe > head > bypass)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_rf_rd <= '0;
      r_rf_wd <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_pipe_gnt) begin
        r_we    <= 1'b1;
        r_rf_rd <= bus.pipe_rd;
        r_rf_wd <= bus.pipe_data;
      end else if (w_head_wr) begin
        r_we    <= 1'b1;
        r_rf_rd <= r_rd[r_rptr];
        r_rf_wd <= r_data[r_rptr];
      end else if (w_byp) begin
        r_we    <= 1'b1;
        r_rf_rd <= bus.mc_rd;
        r_rf_wd <= bus.mc_data;
      end
    end
  end

  assign bus.mc_ready   = ~w_full;
  assign bus.rf_we      = r_we;
  assign bus.rf_rd      = r_rf_rd;
  assign bus.rf_wd      = r_rf_wd;
  assign bus.stall_pipe = r_stall;
  assign bus.fifo_count = r_cnt;
  assign bus.proto_err  = r_err;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          k;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve;
  bit          m_stall, m_err, m_we, m_xfer;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_err    = 1'b0;
    m_we     = 1'b0;
    m_xfer   = 1'b0;
    m_rd     = '0;
    m_wd     = '0;
  endtask

  // One clock of the arbitration rules, applied to the queue
  task automatic model_step(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                            input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    bit   empty0 = (m_q.size() == 0);
    bit   pg     = !m_stall && pwe && (prd != 5'd0);
    bit   lose   = 1'b0;
    bit   hw     = 1'b0;
    bit   keep;
    bit   stall_n;
    ent_t h;
    m_xfer = mv && (m_q.size() < DEPTH);
    m_err  = m_err | (m_stall & pwe);
    m_we   = 1'b0;
    if (pg) begin
      foreach (m_q[i]) if (m_q[i].rd == prd) m_q[i].k = 1'b1;
      m_we = 1'b1; m_rd = prd; m_wd = pd;
    end
    if (!empty0) begin
      if (pg) begin
        if (m_q[0].k) m_q.delete(0);
        else lose = 1'b1;
      end else begin
        h = m_q.pop_front();
        if (!h.k) begin hw = 1'b1; m_we = 1'b1; m_rd = h.rd; m_wd = h.d; end
      end
    end
    keep = m_xfer && (mrd != 5'd0) && !(pg && mrd == prd);
    if (keep) begin
      if (BYP && empty0 && !m_stall && !pg) begin
        m_we = 1'b1; m_rd = mrd; m_wd = md;
      end else begin
        m_q.push_back('{mrd, md, 1'b0});
      end
    end
    stall_n = lose && (m_starve == STARVE_LIMIT - 1);
    if (hw || empty0) m_starve = 0;
    else if (lose)    m_starve++;
    m_stall = stall_n;
  endtask

  task automatic check_outs();
    chk("rf_we", 32'(bus.rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
      chk("rf_wd", bus.rf_wd, m_wd);
    end
    chk("stall_pipe", 32'(bus.stall_pipe), 32'(m_stall));
    chk("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
    chk("mc_ready", 32'(bus.mc_ready), 32'(m_q.size() < DEPTH));
    chk("proto_err", 32'(bus.proto_err), 32'(m_err));
  endtask

  task automatic cyc(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                     input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    @(negedge clk);
    bus.pipe_we = pwe; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.mc_valid = mv; bus.mc_rd = mrd; bus.mc_data = md;
    @(posedge clk);
    model_step(pwe, prd, pd, mv, mrd, md);
    #1 check_outs();
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (bus.fifo_count != '0 && n < 20) begin idle(); n++; end
    chk("drain_timeout", 32'(bus.fifo_count), 32'd0);
    idle();
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    bus.pipe_we = 1'b0; bus.mc_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_rf_rd"}, 32'(bus.rf_rd), 32'd0);
    chk({tag, "_rf_wd"}, bus.rf_wd, 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall_pipe), 32'd0);
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
    chk({tag, "_ready"}, 32'(bus.mc_ready), 32'd1);
    chk({tag, "_err"}, 32'(bus.proto_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pipe hammers rd=1 until the pushed head forces a stall; returns cycles taken
  task automatic starve_to_stall(output int k);
    k = 1;
    cyc(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
    while (!bus.stall_pipe && k < 10) begin
      cyc(1'b1, 5'd1, 32'(k), 1'b0, 5'd0, 32'd0);
      k++;
    end
  endtask

  task automatic rand_run(input int n, input int ppct, input int mpct);
    bit          pend = 1'b0;
    logic [4:0]  mrd  = '0;
    logic [31:0] md   = '0;
    for (int i = 0; i < n; i++) begin
      if (!pend && $urandom_range(99) < mpct) begin
        pend = 1'b1; mrd = 5'($urandom_range(7)); md = $urandom;
      end
      cyc(!m_stall && ($urandom_range(99) < ppct), 5'($urandom_range(7)), $urandom,
          pend, mrd, md);
      if (m_xfer) pend = 1'b0;
    end
  endtask

  initial begin
    int k;
    bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.mc_valid = 1'b0; bus.mc_rd = '0; bus.mc_data = '0;
    model_reset();
    reset_check("reset");

    // 1: plain pipeline write
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("t1_rf_wd", bus.rf_wd, 32'hDEADBEEF);

    // 2: mc result while pipe idle, latency 2 (1 with bypass)
    idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    chk("t2_we_first", 32'(bus.rf_we), 32'(BYP));
    idle();
    chk("t2_we_second", 32'(bus.rf_we), 32'(!BYP));

    // 3: starvation forces a one-cycle stall, head then drains
    drain();
    starve_to_stall(k);
    chk("t3_stall_cycle", 32'(k), 32'd5);
    idle();
    chk("t3_rf_rd", 32'(bus.rf_rd), 32'd9);
    chk("t3_stall_low", 32'(bus.stall_pipe), 32'd0);
    chk("t3_count", 32'(bus.fifo_count), 32'd0);

    // 5: pipeline write to same rd kills the queued entry
    drain();
    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'hA);
    cyc(1'b1, 5'd6, 32'hB, 1'b0, 5'd0, 32'd0);
    chk("t5_rf_wd", bus.rf_wd, 32'hB);
    chk("t5_count", 32'(bus.fifo_count), 32'd0);
    idle();
    chk("t5_no_write", 32'(bus.rf_we), 32'd0);

    // 4 + 6: fill FIFO under pipe pressure, hold a third request, then reset
    drain();
    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h3);
    cyc(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h4);
    chk("t4_count", 32'(bus.fifo_count), 32'd2);
    chk("t4_ready", 32'(bus.mc_ready), 32'd0);
    cyc(1'b1, 5'd5, 32'h5, 1'b1, 5'd8, 32'h8);
    chk("t4_held", 32'(bus.fifo_count), 32'd2);
    chk("t6_we_before", 32'(bus.rf_we), 32'd1);
    reset_check("t6");
    for (int i = 0; i < 4; i++) idle();

    // randomized traffic: heavy and light pipeline pressure
    rand_run(400, 85, 60);
    rand_run(400, 30, 50);
    rand_run(300, 95, 80);
    drain();

    // protocol violation: pipe_we during stall is ignored and flagged
    starve_to_stall(k);
    cyc(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'd0);
    chk("proto_rf_rd", 32'(bus.rf_rd), 32'd9);
    chk("proto_err_set", 32'(bus.proto_err), 32'd1);
    idle();
    chk("proto_err_sticky", 32'(bus.proto_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
